byte_serializer: RTL

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/ff_pkg.sv | 11 +
 rtl/byte_serializer_bit_cnt.sv | 26 ++
 rtl/byte_serializer.sv | 109 ++++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// Shared types and constants for the byte serializer.
package ff_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/byte_serializer_bit_cnt.sv
// Loadable down-counter that tracks how many bits of the word remain after the current one.
module bit_cnt #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_dec,
   output logic [CW-1:0] o_cnt,
   output logic          o_zero
);

   logic [CW-1:0] r_cnt;

   // Load takes priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      r_cnt <= '0;
      else if (i_load)                 r_cnt <= i_load_val;
      else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - CW'(1);
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides; a new word
// can be taken on the cycle the last bit of the current one is consumed.
module byte_serializer
   import ff_pkg::*;
#(
   parameter int WIDTH     = SER_DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   output logic             sout,
   output logic             sout_valid,
   input  logic             sout_ready,
   output logic             sout_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   ser_state_t       r_state;
   ser_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic             r_sout;
   logic             r_vld;
   logic             r_last;
   logic [CW-1:0]    w_cnt;
   logic             w_zero;
   logic             w_fire;
   logic             w_last_fire;
   logic             w_accept;

   assign w_fire      = r_vld & sout_ready;
   assign w_last_fire = w_fire & r_last;
   assign w_accept    = d_valid & d_ready;

   bit_cnt #(.CW(CW)) u_bit_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val (CW'(WIDTH-1)),
      .i_dec      (w_fire & ~w_zero & ~w_accept),
      .o_cnt      (w_cnt),
      .o_zero     (w_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and upstream ready; ready opens only when idle or on a consumed last bit.
   always_comb begin
      w_state_nxt = r_state;
      d_ready     = 1'b0;
      case (r_state)
         IDLE: begin
            d_ready = reset;
            if (d_valid && reset) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            d_ready = reset & w_last_fire;
            if (w_last_fire) w_state_nxt = (d_valid && reset) ? SHIFT : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: load on accept, shift on consume, clear when the word drains.
   // sout is kept in its own flop so the output never passes through a mux.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shreg <= '0;
         r_sout  <= 1'b0;
         r_vld   <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_accept) begin
         r_shreg <= d;
         r_sout  <= MSB_FIRST ? d[WIDTH-1] : d[0];
         r_vld   <= 1'b1;
         r_last  <= 1'b0;
      end else if (w_fire) begin
         if (r_last) begin
            r_shreg <= '0;
            r_sout  <= 1'b0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
         end else begin
            if (MSB_FIRST) begin
               r_shreg <= r_shreg << 1;
               r_sout  <= r_shreg[WIDTH-2];
            end else begin
               r_shreg <= r_shreg >> 1;
               r_sout  <= r_shreg[1];
            end
            r_last <= (w_cnt == CW'(1));
         end
      end
   end

   assign sout       = r_sout;
   assign sout_valid = r_vld;
   assign sout_last  = r_last;
   assign busy       = (r_state == SHIFT);

endmodule
